// File: rtl/ssd_pkg.sv
// Shared segment constants and the BCD-to-segment decoder for the scanned display driver.
// Segment vectors are ordered g..a and are active-low (0 lights the segment).
package ssd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ERR   = 7'b0000110;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_ERR;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_tick_div.sv
// Free-running modulo-DIV counter. tick is high during the last count (cnt == DIV-1),
// i.e. on the cycle whose rising edge wraps the counter back to zero.
module ssd_tick_div #(
    parameter int DIV = 4,
    parameter int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [CW-1:0] cnt,
    output logic          tick
);

    assign tick = (cnt == CW'(DIV - 1));

    // Count 0..DIV-1 and wrap; never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bcd_ssd_scan.sv
// Time-multiplexed BCD to seven-segment driver for a common-anode display.
// A loaded word waits in pend and is promoted to active only at a slot boundary, so a
// digit never changes mid-slot. Each slot starts with GUARD dark cycles to stop ghosting.
// Output priority: guard > blink > leading-zero blank > decode.
module bcd_ssd_scan
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2,
    parameter int BLINK_DIV   = 12500000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    output logic [6:0]              HEX,
    output logic [NUM_DIGITS-1:0]   AN
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [REF_W-1:0]        ref_cnt;
    logic                    slot_end;
    logic [BLK_W-1:0]        blink_cnt_unused;
    logic                    blink_tick;
    logic                    phase;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] pend;
    logic [4*NUM_DIGITS-1:0] active;

    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              cur_digit;
    logic                    cur_lz;
    logic                    cur_blink;
    logic [NUM_DIGITS-1:0]   cur_an;
    logic [6:0]              hex_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;

    ssd_tick_div #(.DIV(REFRESH_DIV), .CW(REF_W)) u_slot_div (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (ref_cnt),
        .tick  (slot_end)
    );

    ssd_tick_div #(.DIV(BLINK_DIV), .CW(BLK_W)) u_blink_div (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (blink_cnt_unused),
        .tick  (blink_tick)
    );

    // Blink phase flips every BLINK_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 1'b0;
        end else if (blink_tick) begin
            phase <= ~phase;
        end
    end

    // Advance to the next digit at each slot boundary, wrapping after the top digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (slot_end) begin
            if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Capture loads into pend; promote to active only at a slot boundary (load on the
    // boundary cycle goes straight through so it is not delayed by a whole slot).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= '0;
            active <= '0;
        end else begin
            if (load) begin
                pend <= bcd;
            end
            if (slot_end) begin
                active <= load ? bcd : pend;
            end
        end
    end

    // Leading-zero mask: digit i blanks when it and every digit above it are zero.
    always_comb begin
        lz_mask = '0;
        lz_mask[NUM_DIGITS-1] = (active[4*NUM_DIGITS-1 -: 4] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 1; i--) begin
            lz_mask[i] = lz_mask[i+1] && (active[4*i +: 4] == 4'd0);
        end
        lz_mask[0] = 1'b0;
    end

    // Select the current digit's value, blank flags and anode pattern.
    always_comb begin
        cur_digit = 4'd0;
        cur_lz    = 1'b0;
        cur_blink = 1'b0;
        cur_an    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit = active[4*i +: 4];
                cur_lz    = lz_mask[i];
                cur_blink = blink_en[i];
                cur_an[i] = 1'b0;
            end
        end
    end

    // Output mux in priority order: guard, blink, leading-zero, decode.
    always_comb begin
        hex_nxt = SEG_BLANK;
        an_nxt  = '1;
        if (ref_cnt < REF_W'(GUARD)) begin
            hex_nxt = SEG_BLANK;
            an_nxt  = '1;
        end else if (phase && cur_blink) begin
            hex_nxt = SEG_BLANK;
            an_nxt  = '1;
        end else if (blank_lz && cur_lz) begin
            hex_nxt = SEG_BLANK;
            an_nxt  = cur_an;
        end else begin
            hex_nxt = bcd_to_seg(cur_digit);
            an_nxt  = cur_an;
        end
    end

    // Register the pins so the display sees glitch-free segment and anode drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            HEX <= SEG_BLANK;
            AN  <= '1;
        end else begin
            HEX <= hex_nxt;
            AN  <= an_nxt;
        end
    end

endmodule
